fetch_unit: RTL and testbench

Instruction-fetch stage directly upstream of the control unit in the single-cycle RISC-V core. It holds the PC and requests instructions from instruction memory over a valid/ready request and response handshake. It presents the captured instruction, with Op, funct3 and funct7 split out for decode. On consume it advances the PC by 4, or by the immediate when PCSrc is asserted.

---
 rtl/fetch_pkg.sv | 22 ++
 rtl/fetch_if.sv | 31 +++
 rtl/fetch_pc_next.sv | 27 ++
 rtl/fetch_unit.sv | 98 +++++++++
 tb/tb_fetch_unit.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage: FSM states,
// reset instruction, PC step and the decode field positions within Instr.
package fetch_pkg;

  typedef enum logic [1:0] {
    REQ   = 2'd0,
    WAIT  = 2'd1,
    ISSUE = 2'd2,
    TRAP  = 2'd3
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int          PC_STEP   = 4;

  localparam int OP_LSB = 0;
  localparam int OP_MSB = 6;
  localparam int F3_LSB = 12;
  localparam int F3_MSB = 14;
  localparam int F7_LSB = 25;
  localparam int F7_MSB = 31;

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory port of the fetch stage: one request channel and one
// response channel.
interface fetch_if #(
  parameter int XLEN = 32
);
  // Request: a transfer happens on a rising edge with imem_req_valid and
  // imem_req_ready both high; imem_addr is held stable while valid waits for
  // ready. Response: imem_rsp_valid has no back-pressure and is taken only by
  // a fetcher that is waiting for it.
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;

  modport master (
    output imem_req_valid,
    output imem_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );
endinterface

// File: rtl/fetch_pc_next.sv
// Combinational next-PC: PC+4 or PC+ImmExt. With FETCH_ALIGN_CHECK_EN the raw
// target is kept and flagged when misaligned; otherwise its low bits are cleared.
module fetch_pc_next
  import fetch_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm_ext,
  input  logic            pc_src,
  output logic [XLEN-1:0] next_pc,
  output logic            misaligned
);

  logic [XLEN-1:0] offset;

  assign offset = pc_src ? imm_ext : XLEN'(PC_STEP);

`ifdef FETCH_ALIGN_CHECK_EN
  assign next_pc    = pc + offset;
  assign misaligned = |next_pc[1:0];
`else
  assign next_pc    = (pc + offset) & ~XLEN'(3);
  assign misaligned = 1'b0;
`endif

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: REQ -> WAIT -> ISSUE loop holding PC, the captured
// instruction and a retired counter. Optional TRAP via FETCH_ALIGN_CHECK_EN.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            PCSrc,
  input  logic [XLEN-1:0] ImmExt,
  input  logic            instr_ready,
  fetch_if.master         imem,
  output logic [31:0]     Instr,
  output logic [6:0]      Op,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7,
  output logic [XLEN-1:0] PC,
  output logic            instr_valid,
  output logic [31:0]     retired,
  output logic            misalign,
  output fetch_state_e    dbg_state
);

  fetch_state_e    state, next_state;
  logic [XLEN-1:0] next_pc;
  logic            pc_misaligned;
  logic            consume;
  logic            capture;

  fetch_pc_next #(.XLEN(XLEN)) u_pc_next (
    .pc         (PC),
    .imm_ext    (ImmExt),
    .pc_src     (PCSrc),
    .next_pc    (next_pc),
    .misaligned (pc_misaligned)
  );

  // Only ISSUE holds a valid instruction, so consume outside it is ignored.
  assign consume   = (state == ISSUE) && instr_ready;
  assign capture   = (state == WAIT) && imem.imem_rsp_valid;
  assign imem.imem_addr = PC;
  assign dbg_state = state;

  assign Op     = Instr[OP_MSB:OP_LSB];
  assign funct3 = Instr[F3_MSB:F3_LSB];
  assign funct7 = Instr[F7_MSB:F7_LSB];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= REQ;
    else      state <= next_state;
  end

  always_comb begin
    next_state          = state;
    imem.imem_req_valid = 1'b0;
    case (state)
      REQ: begin
        imem.imem_req_valid = 1'b1;
        if (imem.imem_req_ready) next_state = WAIT;
      end
      WAIT:    if (imem.imem_rsp_valid) next_state = ISSUE;
      ISSUE:   if (instr_ready) next_state = pc_misaligned ? TRAP : REQ;
      TRAP:    next_state = TRAP;
      default: next_state = REQ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      PC          <= RESET_PC;
      Instr       <= NOP_INSTR;
      instr_valid <= 1'b0;
      retired     <= '0;
    end else begin
      if (capture) begin
        Instr       <= imem.imem_rsp_data;
        instr_valid <= 1'b1;
      end
      if (consume) begin
        PC          <= next_pc;
        retired     <= retired + 32'd1;
        instr_valid <= 1'b0;
      end
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                         misalign <= 1'b0;
    else if (consume && pc_misaligned) misalign <= 1'b1;
  end
`else
  assign misalign = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: the bench plays instruction memory and datapath and
// predicts every request address, captured word and retired count.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  int unsigned cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  logic         pc_src;
  logic [31:0]  imm_ext;
  logic         instr_ready;
  logic [31:0]  instr;
  logic [6:0]   op;
  logic [2:0]   funct3;
  logic [6:0]   funct7;
  logic [31:0]  pc;
  logic         instr_valid;
  logic [31:0]  retired;
  logic         misalign;
  fetch_state_e dbg_state;

  fetch_if #(.XLEN(32)) imem ();

  fetch_unit #(.XLEN(32), .RESET_PC(RST_PC)) dut (
    .clk         (clk),
    .rst         (rst),
    .PCSrc       (pc_src),
    .ImmExt      (imm_ext),
    .instr_ready (instr_ready),
    .imem        (imem.master),
    .Instr       (instr),
    .Op          (op),
    .funct3      (funct3),
    .funct7      (funct7),
    .PC          (pc),
    .instr_valid (instr_valid),
    .retired     (retired),
    .misalign    (misalign),
    .dbg_state   (dbg_state)
  );

  // scoreboard: expected request addresses, retired count
  logic [31:0] exp_q[$];
  logic [31:0] exp_ret;
  bit          trapped;
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_req_valid"}, 32'(imem.imem_req_valid), 32'd1);
    check({tag, "_addr"}, imem.imem_addr, RST_PC);
    check({tag, "_pc"}, pc, RST_PC);
    check({tag, "_instr"}, instr, 32'h0000_0013);
    check({tag, "_op"}, 32'(op), 32'h13);
    check({tag, "_f3"}, 32'(funct3), 32'd0);
    check({tag, "_f7"}, 32'(funct7), 32'd0);
    check({tag, "_ivalid"}, 32'(instr_valid), 32'd0);
    check({tag, "_retired"}, retired, 32'd0);
    check({tag, "_misalign"}, 32'(misalign), 32'd0);
  endtask

  function automatic logic [31:0] pop_addr();
    if (exp_q.size() == 0) return 32'hDEAD_BEEF;
    return exp_q.pop_front();
  endfunction

  // driver: one full request / response / issue / consume transaction
  task automatic fetch_one(input int req_dly, input int rsp_dly, input int iss_dly,
                           input bit spur, input bit src, input logic [31:0] imm);
    logic [31:0] word, addr, nxt;
    int unsigned t0;
    if (trapped) return;
    t0   = cyc;
    addr = pop_addr();
    check("req_valid", 32'(imem.imem_req_valid), 32'd1);
    check("req_addr", imem.imem_addr, addr);
    repeat (req_dly) begin
      instr_ready = 1'($urandom_range(0, 1));
      tick();
      check("req_hold_valid", 32'(imem.imem_req_valid), 32'd1);
      check("req_hold_addr", imem.imem_addr, addr);
    end
    imem.imem_req_ready = 1'b1;
    tick();
    imem.imem_req_ready = 1'b0;
    check("wait_no_req", 32'(imem.imem_req_valid), 32'd0);
    repeat (rsp_dly) tick();
    word = $urandom;
    imem.imem_rsp_valid = 1'b1;
    imem.imem_rsp_data  = word;
    tick();
    imem.imem_rsp_valid = 1'b0;
    instr_ready         = 1'b0;
    check("ivalid", 32'(instr_valid), 32'd1);
    check("instr", instr, word);
    check("op", 32'(op), 32'(word[6:0]));
    check("funct3", 32'(funct3), 32'(word[14:12]));
    check("funct7", 32'(funct7), 32'(word[31:25]));
    check("pc", pc, addr);
    check("retired_hold", retired, exp_ret);
    if (spur) begin
      imem.imem_rsp_valid = 1'b1;
      imem.imem_rsp_data  = ~word;
      tick();
      imem.imem_rsp_valid = 1'b0;
      check("spur_instr", instr, word);
    end
    repeat (iss_dly) tick();
    check("issue_instr", instr, word);
    check("issue_pc", pc, addr);
    pc_src      = src;
    imm_ext     = imm;
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    pc_src      = 1'b0;
    imm_ext     = '0;
    check("cycles", 32'(cyc - t0), 32'(3 + req_dly + rsp_dly + iss_dly + int'(spur)));
    exp_ret++;
    check("retired", retired, exp_ret);
    check("ivalid_clr", 32'(instr_valid), 32'd0);
    nxt = addr + (src ? imm : 32'd4);
`ifdef FETCH_ALIGN_CHECK_EN
    if (nxt[1:0] != 2'b00) begin
      trapped = 1'b1;
      check("trap_misalign", 32'(misalign), 32'd1);
      check("trap_pc", pc, nxt);
      repeat (3) begin
        tick();
        check("trap_no_req", 32'(imem.imem_req_valid), 32'd0);
        check("trap_ivalid", 32'(instr_valid), 32'd0);
      end
      return;
    end
`endif
    nxt[1:0] = 2'b00;
    check("misalign", 32'(misalign), 32'd0);
    exp_q.push_back(nxt);
  endtask

  task automatic reset_in_wait();
    logic [31:0] addr;
    addr = pop_addr();
    check("rw_addr", imem.imem_addr, addr);
    imem.imem_req_ready = 1'b1;
    tick();
    imem.imem_req_ready = 1'b0;
    rst = 1'b0;
    #1;
    check_reset_values("rw_async");
    tick();
    rst = 1'b1;
    // stale response while REQ is pending again must be dropped
    imem.imem_rsp_valid = 1'b1;
    imem.imem_rsp_data  = 32'hBADC_0FFE;
    tick();
    imem.imem_rsp_valid = 1'b0;
    check("rw_stale_instr", instr, 32'h0000_0013);
    check("rw_stale_ivalid", 32'(instr_valid), 32'd0);
    exp_q.delete();
    exp_q.push_back(RST_PC);
    exp_ret = '0;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] imm;
    rst                 = 1'b0;
    pc_src              = 1'b0;
    imm_ext             = '0;
    instr_ready         = 1'b0;
    imem.imem_req_ready = 1'b0;
    imem.imem_rsp_valid = 1'b0;
    imem.imem_rsp_data  = '0;
    exp_ret             = '0;
    trapped             = 1'b0;
    repeat (3) tick();
    check_reset_values("reset");
    check("reset_state", 32'(dbg_state), 32'(REQ));
    rst = 1'b1;
    exp_q.push_back(RST_PC);

    // sequential fetch at minimum throughput, then a backward branch
    repeat (3) fetch_one(0, 0, 0, 1'b0, 1'b0, 32'd0);
    fetch_one(0, 0, 0, 1'b0, 1'b1, 32'hFFFF_FFF8);
    // back-pressure on request and on consume, spurious response
    fetch_one(5, 0, 4, 1'b0, 1'b0, 32'd0);
    fetch_one(0, 2, 1, 1'b1, 1'b0, 32'd0);
    reset_in_wait();
    fetch_one(0, 0, 0, 1'b0, 1'b0, 32'd0);
    // PC wrap through the top of the address space
    fetch_one(0, 0, 0, 1'b0, 1'b1, 32'hFFFF_FEF8);
    fetch_one(0, 0, 0, 1'b0, 1'b0, 32'd0);
    fetch_one(1, 1, 0, 1'b0, 1'b1, 32'd64);

    for (int i = 0; i < 40; i++) begin
      imm = 32'($urandom_range(0, 32)) - 32'd16;
`ifdef FETCH_ALIGN_CHECK_EN
      imm = imm << 2;
`endif
      fetch_one($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), imm);
    end

    // misaligned branch target: trap with the macro, cleared low bits without
    fetch_one(0, 0, 0, 1'b0, 1'b1, 32'd2);
    fetch_one(0, 0, 0, 1'b0, 1'b0, 32'd0);
`ifdef FETCH_ALIGN_CHECK_EN
    check("trap_reached", 32'(trapped), 32'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
